// File: rtl/splash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : splash_pkg
// Brief    : Shared types and screen geometry for the XO splash sequencer.
// Revision : 1.0
// ============================================================================
package splash_pkg;

    localparam int unsigned H_RES    = 640;
    localparam int unsigned V_RES    = 480;
    localparam int unsigned SPLASH_W = 296;
    localparam int unsigned SPLASH_H = 65;

    localparam int unsigned X_W = 10;
    localparam int unsigned Y_W = 9;

    typedef enum logic [1:0] {
        SLIDE_IN  = 2'd0,
        HOLD      = 2'd1,
        SLIDE_OUT = 2'd2,
        GAME      = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/splash_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : splash_ctrl_if
// Brief    : Control inputs and renderer-facing outputs of the splash sequencer.
// Revision : 1.0
// ============================================================================
interface splash_ctrl_if;
    import splash_pkg::*;

    logic           frame_tick;
    logic           start_btn;
    logic           game_over;
    logic [X_W-1:0] splash_x;
    logic [Y_W-1:0] splash_y;
    logic           splash_en;
    logic           game_active;
    logic [1:0]     state_o;

    modport master (
        input  frame_tick, start_btn, game_over,
        output splash_x, splash_y, splash_en, game_active, state_o
    );

    modport slave (
        output frame_tick, start_btn, game_over,
        input  splash_x, splash_y, splash_en, game_active, state_o
    );

endinterface
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_sync_edge
// Brief    : Two-flop synchronizer plus rising-edge detector for a raw button.
// Revision : 1.0
// ============================================================================
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async_in,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/splash_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : splash_ctrl
// Brief    : Slide-in / blink / slide-out sequencer for the title splash.
// Revision : 1.0
// ============================================================================
module splash_ctrl
    import splash_pkg::*;
#(
    parameter int unsigned TARGET_X        = (H_RES - SPLASH_W) / 2,
    parameter int unsigned TARGET_Y        = (V_RES - SPLASH_H) / 2,
    parameter int unsigned Y_START         = 0,
    parameter int unsigned STEP            = 4,
    parameter int unsigned BLINK_FRAMES    = 30,
    parameter int unsigned MIN_HOLD_FRAMES = 60
) (
    input  logic          clk,
    input  logic          rst_n,
    splash_ctrl_if.master bus
);

    localparam int unsigned HC_W = $clog2(MIN_HOLD_FRAMES + 1);
    localparam int unsigned BC_W = $clog2(BLINK_FRAMES);

    localparam logic [X_W-1:0]  c_TARGET_X   = X_W'(TARGET_X);
    localparam logic [Y_W-1:0]  c_TARGET_Y   = Y_W'(TARGET_Y);
    localparam logic [Y_W-1:0]  c_Y_START    = Y_W'(Y_START);
    localparam logic [Y_W-1:0]  c_STEP       = Y_W'(STEP);
    localparam logic [Y_W:0]    c_STEP_EXT   = (Y_W+1)'(STEP);
    localparam logic [HC_W-1:0] c_MIN_HOLD   = HC_W'(MIN_HOLD_FRAMES);
    localparam logic [BC_W-1:0] c_BLINK_LAST = BC_W'(BLINK_FRAMES - 1);

    state_t          r_state,     w_state_nxt;
    logic [Y_W-1:0]  r_y,         w_y_nxt;
    logic [HC_W-1:0] r_hold_cnt,  w_hold_cnt_nxt;
    logic [BC_W-1:0] r_blink_cnt, w_blink_cnt_nxt;
    logic            r_blink_on,  w_blink_on_nxt;
    logic            r_en,        w_en_nxt;
    logic            r_game,      w_game_nxt;
    logic [Y_W:0]    w_sum;
    logic            w_press;

    btn_sync_edge u_btn (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_async_in (bus.start_btn),
        .o_rise     (w_press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SLIDE_IN;
            r_y         <= c_Y_START;
            r_hold_cnt  <= '0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
            r_en        <= 1'b1;
            r_game      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_y         <= w_y_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink_on  <= w_blink_on_nxt;
            r_en        <= w_en_nxt;
            r_game      <= w_game_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_y_nxt         = r_y;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_blink_cnt_nxt = r_blink_cnt;
        w_blink_on_nxt  = r_blink_on;
        // Extra bit so a large STEP near the bottom cannot wrap past TARGET_Y.
        w_sum           = {1'b0, r_y} + c_STEP_EXT;

        case (r_state)
            SLIDE_IN: begin
                if (w_press || (bus.frame_tick && (w_sum >= {1'b0, c_TARGET_Y}))) begin
                    w_y_nxt         = c_TARGET_Y;
                    w_state_nxt     = HOLD;
                    w_hold_cnt_nxt  = '0;
                    w_blink_cnt_nxt = '0;
                    w_blink_on_nxt  = 1'b1;
                end else if (bus.frame_tick) begin
                    w_y_nxt = w_sum[Y_W-1:0];
                end
            end
            HOLD: begin
                if (bus.frame_tick) begin
                    if (r_hold_cnt < c_MIN_HOLD) begin
                        w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                    end
                    if (r_blink_cnt == c_BLINK_LAST) begin
                        w_blink_cnt_nxt = '0;
                        w_blink_on_nxt  = ~r_blink_on;
                    end else begin
                        w_blink_cnt_nxt = r_blink_cnt + 1'b1;
                    end
                end
                // Press is judged on the count before this cycle's tick lands.
                if (w_press && (r_hold_cnt >= c_MIN_HOLD)) begin
                    w_state_nxt    = SLIDE_OUT;
                    w_blink_on_nxt = 1'b1;
                end
            end
            SLIDE_OUT: begin
                if (bus.frame_tick) begin
                    if (r_y <= c_STEP) begin
                        w_y_nxt     = c_Y_START;
                        w_state_nxt = GAME;
                    end else begin
                        w_y_nxt = r_y - c_STEP;
                    end
                end
            end
            GAME: begin
                if (bus.game_over) begin
                    w_y_nxt     = c_Y_START;
                    w_state_nxt = SLIDE_IN;
                end
            end
            default: begin
                w_state_nxt = SLIDE_IN;
            end
        endcase

        case (w_state_nxt)
            HOLD:    w_en_nxt = w_blink_on_nxt;
            GAME:    w_en_nxt = 1'b0;
            default: w_en_nxt = 1'b1;
        endcase
        w_game_nxt = (w_state_nxt == GAME);
    end

    assign bus.splash_x    = c_TARGET_X;
    assign bus.splash_y    = r_y;
    assign bus.splash_en   = r_en;
    assign bus.game_active = r_game;
    assign bus.state_o     = r_state;

endmodule
`default_nettype wire
